// File: rtl/risc_pkg.sv
// Shared RISC core definitions: flag bit positions and the flag word type.
package risc_pkg;
  localparam int FLAG_W = 3;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  typedef logic [FLAG_W-1:0] flags_t;
endpackage

// File: rtl/ccr_flag_unit_if.sv
// Execute-stage <-> condition-code register bus.
interface ccr_flag_unit_if #(parameter int SAVE_DEPTH = 2);
  import risc_pkg::*;
  localparam int DW = $clog2(SAVE_DEPTH + 1);

  flags_t          alu_flags;
  flags_t          alu_flags_we;
  logic            stall;
  logic            flush;
  logic            int_save;
  logic            rti_restore;
  flags_t          flags;
  logic [DW-1:0]   save_depth;
  logic            lifo_full;
  logic            lifo_err;

  modport master (output alu_flags, alu_flags_we, stall, flush, int_save, rti_restore,
                  input  flags, save_depth, lifo_full, lifo_err);
  modport slave  (input  alu_flags, alu_flags_we, stall, flush, int_save, rti_restore,
                  output flags, save_depth, lifo_full, lifo_err);
endinterface

// File: rtl/ccr_flag_unit_lifo.sv
// Saturating flag-word stack for nested interrupts; err is sticky until reset.
module ccr_flag_lifo
  import risc_pkg::*;
#(
  parameter int SAVE_DEPTH = 2,
  parameter int DW = $clog2(SAVE_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  flags_t        din,
  output flags_t        top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic          err
);
  flags_t [SAVE_DEPTH-1:0] mem;

  assign full  = (depth == DW'(SAVE_DEPTH));
  assign empty = (depth == '0);

  always_comb begin
    top = '0;
    for (int i = 0; i < SAVE_DEPTH; i++)
      if (!empty && DW'(i) == depth - DW'(1)) top = mem[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem   <= '0;
      depth <= '0;
      err   <= 1'b0;
    end else if (pop) begin
      if (empty) err <= 1'b1;
      else       depth <= depth - DW'(1);
    end else if (push) begin
      if (full) err <= 1'b1;
      else begin
        for (int i = 0; i < SAVE_DEPTH; i++)
          if (DW'(i) == depth) mem[i] <= din;
        depth <= depth + DW'(1);
      end
    end
  end
endmodule

// File: rtl/ccr_flag_unit.sv
// Condition-code register with masked ALU update and interrupt save LIFO.
// Optional CCR_FLAG_BYPASS_EN: forward next flags combinationally to consumers.
module ccr_flag_unit
  import risc_pkg::*;
#(
  parameter int SAVE_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  ccr_flag_unit_if.slave   bus
);
  localparam int DW = $clog2(SAVE_DEPTH + 1);

  flags_t        flags_q, flags_nxt, merged, we_eff, lifo_top;
  logic          push, pop, lifo_empty;
  logic [DW-1:0] depth;

  // A squashed instruction contributes no flag bits.
  assign we_eff = bus.flush ? '0 : bus.alu_flags_we;
  assign merged = (flags_q & ~we_eff) | (bus.alu_flags & we_eff);

  // Restore has priority; a save in the same cycle is dropped silently.
  assign pop  = !bus.stall && bus.rti_restore;
  assign push = !bus.stall && bus.int_save && !bus.rti_restore;

  always_comb begin
    flags_nxt = flags_q;
    if (!bus.stall) begin
      if (bus.rti_restore && !lifo_empty) flags_nxt = lifo_top;
      else                                flags_nxt = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_nxt;
  end

  ccr_flag_lifo #(.SAVE_DEPTH(SAVE_DEPTH), .DW(DW)) u_lifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (merged),
    .top   (lifo_top),
    .depth (depth),
    .full  (bus.lifo_full),
    .empty (lifo_empty),
    .err   (bus.lifo_err)
  );

  assign bus.save_depth = depth;
`ifdef CCR_FLAG_BYPASS_EN
  assign bus.flags = flags_nxt;
`else
  assign bus.flags = flags_q;
`endif
endmodule

// File: tb/tb_ccr_flag_unit.sv
// Directed vector bench for ccr_flag_unit (default and CCR_FLAG_BYPASS_EN builds).
module tb_ccr_flag_unit;
  import risc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ccr_flag_unit_if #(.SAVE_DEPTH(2)) bus ();
  ccr_flag_unit #(.SAVE_DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    string      name;
    logic       rst_n;
    logic [2:0] alu, we;
    logic       stall, flush, sv, rti;
    logic [2:0] ef;
    logic [1:0] ed;
    logic       efull, eerr;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic r, input logic [2:0] alu, input logic [2:0] we,
                     input logic st, input logic fl, input logic sv, input logic rti,
                     input logic [2:0] ef, input logic [1:0] ed, input logic efull, input logic eerr);
    vec_t v;
    v.name = name; v.rst_n = r; v.alu = alu; v.we = we; v.stall = st; v.flush = fl;
    v.sv = sv; v.rti = rti; v.ef = ef; v.ed = ed; v.efull = efull; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  task automatic idle();
    rst_n = 1'b1;
    bus.alu_flags = '0; bus.alu_flags_we = '0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.int_save = 1'b0; bus.rti_restore = 1'b0;
  endtask

  initial begin
    //   name            rst alu     we      st fl sv rti  flags   d  full err
    add("reset",         0, 3'b111, 3'b111, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    add("mask101",       1, 3'b111, 3'b101, 0, 0, 0, 0, 3'b101, 0, 0, 0);
    add("mask0",         1, 3'b111, 3'b000, 0, 0, 0, 0, 3'b101, 0, 0, 0);
    add("set001",        1, 3'b001, 3'b111, 0, 0, 0, 0, 3'b001, 0, 0, 0);
    add("flush",         1, 3'b110, 3'b111, 0, 1, 0, 0, 3'b001, 0, 0, 0);
    add("stall_save",    1, 3'b110, 3'b111, 1, 0, 1, 0, 3'b001, 0, 0, 0);
    add("stall_rti",     1, 3'b110, 3'b111, 1, 0, 0, 1, 3'b001, 0, 0, 0);
    add("set010",        1, 3'b010, 3'b111, 0, 0, 0, 0, 3'b010, 0, 0, 0);
    add("push110",       1, 3'b100, 3'b100, 0, 0, 1, 0, 3'b110, 1, 0, 0);
    add("set001b",       1, 3'b001, 3'b111, 0, 0, 0, 0, 3'b001, 1, 0, 0);
    add("push001",       1, 3'b000, 3'b000, 0, 0, 1, 0, 3'b001, 2, 1, 0);
    add("pop001",        1, 3'b111, 3'b111, 0, 0, 0, 1, 3'b001, 1, 0, 0);
    add("pop110",        1, 3'b111, 3'b111, 0, 0, 0, 1, 3'b110, 0, 0, 0);
    add("fill1",         1, 3'b011, 3'b111, 0, 0, 1, 0, 3'b011, 1, 0, 0);
    add("fill2",         1, 3'b000, 3'b000, 0, 0, 1, 0, 3'b011, 2, 1, 0);
    add("push_full",     1, 3'b100, 3'b111, 0, 0, 1, 0, 3'b100, 2, 1, 1);
    add("err_sticky",    1, 3'b000, 3'b000, 0, 0, 0, 0, 3'b100, 2, 1, 1);
    add("reset2",        0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    add("pop_empty",     1, 3'b101, 3'b111, 0, 0, 0, 1, 3'b101, 0, 0, 1);
    add("reset3",        0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    add("push010",       1, 3'b010, 3'b111, 0, 0, 1, 0, 3'b010, 1, 0, 0);
    add("save_and_rti",  1, 3'b111, 3'b111, 0, 0, 1, 1, 3'b010, 0, 0, 0);

    idle();
    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      bus.alu_flags = vecs[i].alu; bus.alu_flags_we = vecs[i].we;
      bus.stall = vecs[i].stall; bus.flush = vecs[i].flush;
      bus.int_save = vecs[i].sv; bus.rti_restore = vecs[i].rti;
      @(posedge clk);
      #1 idle();
      #1;
      chk({vecs[i].name, ".flags"}, {1'b0, bus.flags},      {1'b0, vecs[i].ef});
      chk({vecs[i].name, ".depth"}, {2'b0, bus.save_depth}, {2'b0, vecs[i].ed});
      chk({vecs[i].name, ".full"},  {3'b0, bus.lifo_full},  {3'b0, vecs[i].efull});
      chk({vecs[i].name, ".err"},   {3'b0, bus.lifo_err},   {3'b0, vecs[i].eerr});
    end

    // Same-cycle visibility of a write; flags currently 3'b010.
    @(negedge clk);
    bus.alu_flags = 3'b011; bus.alu_flags_we = 3'b111;
    #1;
`ifdef CCR_FLAG_BYPASS_EN
    chk("bypass.same", {1'b0, bus.flags}, 4'b0011);
`else
    chk("bypass.same", {1'b0, bus.flags}, 4'b0010);
`endif
    @(posedge clk);
    #1 idle();
    #1 chk("bypass.next", {1'b0, bus.flags}, 4'b0011);

    // Restore visibility: push 3'b110, overwrite, then RTI.
    @(negedge clk);
    bus.alu_flags = 3'b110; bus.alu_flags_we = 3'b111; bus.int_save = 1'b1;
    @(negedge clk);
    idle(); bus.alu_flags = 3'b001; bus.alu_flags_we = 3'b111;
    @(negedge clk);
    idle(); bus.rti_restore = 1'b1; bus.alu_flags = 3'b111; bus.alu_flags_we = 3'b111;
    #1;
`ifdef CCR_FLAG_BYPASS_EN
    chk("rti.same", {1'b0, bus.flags}, 4'b0110);
`else
    chk("rti.same", {1'b0, bus.flags}, 4'b0001);
`endif
    @(posedge clk);
    #1 idle();
    #1;
    chk("rti.next",  {1'b0, bus.flags},      4'b0110);
    chk("rti.depth", {2'b0, bus.save_depth}, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
